// File: rtl/mem_port_scheduler_pkg.sv
// mem_port_scheduler_pkg: shared types, byte-mode encodings and lane helpers for the memory port scheduler
package mem_port_scheduler_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [63:0] reg_t;
    typedef enum logic [1:0] {BMD_B = 2'd0, BMD_H = 2'd1, BMD_W = 2'd2, BMD_D = 2'd3} bmd_t;
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, OUT_WAIT, IN_WAIT} mem_sched_state_t;
    localparam addr_t IO_FILE_POINTER_DEF = 32'hfffff000;
    function automatic logic [3:0] bmd_size(bmd_t b);
        return 4'd1 << b;
    endfunction
    function automatic logic [7:0] bmd_lanes(bmd_t b);
        return 8'((9'd1 << bmd_size(b)) - 9'd1);
    endfunction
endpackage

// File: rtl/mem_port_scheduler_if.sv
// mem_port_scheduler_if: fetch, data, memory-port and OUT/IN handshake signals of the scheduler
// slave: scheduler side; master: requesters, memory and IO side
interface mem_port_scheduler_if;
    import mem_port_scheduler_pkg::*;
    logic        if_req, if_gnt, if_rvalid;
    addr_t       if_addr;
    reg_t        if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_done, dm_err;
    addr_t       dm_addr;
    bmd_t        dm_bmd;
    reg_t        dm_wdata, dm_rdata;
    addr_t       mem_addr;
    logic [7:0]  mem_we;
    reg_t        mem_wdata, mem_rdata;
    logic        out_req, out_ack, in_ready, in_valid;
    logic [31:0] out_data, in_data;
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_bmd, dm_wdata, mem_rdata, out_ack, in_valid, in_data,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_done, dm_rdata, dm_err, mem_addr, mem_we, mem_wdata,
               out_req, out_data, in_ready
    );
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_bmd, dm_wdata, mem_rdata, out_ack, in_valid, in_data,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_done, dm_rdata, dm_err, mem_addr, mem_we, mem_wdata,
               out_req, out_data, in_ready
    );
endinterface

// File: rtl/mem_port_scheduler_byte_lane_align.sv
// byte_lane_align: store lane mask/shift with boundary-crossing check, and load extract with zero-extension
// st_*_i: store offset/mode/data -> st_mask_o, st_wdata_o, st_cross_o
// ld_*_i: load offset/mode/raw word -> ld_rdata_o
module byte_lane_align
    import mem_port_scheduler_pkg::*;
(
    input  logic [2:0] st_off_i,
    input  bmd_t       st_bmd_i,
    input  reg_t       st_wdata_i,
    input  logic [2:0] ld_off_i,
    input  bmd_t       ld_bmd_i,
    input  reg_t       ld_rdata_i,
    output logic [7:0] st_mask_o,
    output reg_t       st_wdata_o,
    output logic       st_cross_o,
    output reg_t       ld_rdata_o
);
    logic [7:0] ld_lanes;
    reg_t       ld_shifted;
    always_comb begin
        st_mask_o  = bmd_lanes(st_bmd_i) << st_off_i;
        st_wdata_o = st_wdata_i << {st_off_i, 3'b000};
        st_cross_o = ({1'b0, st_off_i} + bmd_size(st_bmd_i)) > 4'd8;
        ld_lanes   = bmd_lanes(ld_bmd_i);
        ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_rdata_o = '0;
        for (int i = 0; i < 8; i++) ld_rdata_o[8*i +: 8] = ld_shifted[8*i +: 8] & {8{ld_lanes[i]}};
    end
endmodule

// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler: arbitrates fetch and data requests onto one memory port, sequences loads, routes IO accesses
// clk, rstn (synchronous, active-low); bus: mem_port_scheduler_if.slave
// MEM_SCHED_RR_EN: round-robin arbitration instead of fixed data-over-fetch priority
module mem_port_scheduler
    import mem_port_scheduler_pkg::*;
#(
    parameter int unsigned LOAD_LATENCY    = 1,
    parameter addr_t       IO_FILE_POINTER = IO_FILE_POINTER_DEF
) (
    input logic                 clk,
    input logic                 rstn,
    mem_port_scheduler_if.slave bus
);
`ifdef MEM_SCHED_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif
    mem_sched_state_t state_q;
    logic [2:0]  cnt_q, ld_off_q;
    bmd_t        ld_bmd_q;
    logic        ld_fetch_q, last_data_q, dm_done_q, dm_err_q, out_req_q, in_ready_q;
    logic [7:0]  mem_we_q, st_mask;
    addr_t       mem_addr_q;
    reg_t        mem_wdata_q, dm_rdata_q, if_rdata_q, st_wdata, ld_rdata;
    logic [31:0] out_data_q;
    logic        ld_done, idle, pick_data, dm_gnt, if_gnt, dm_io, st_cross;

    byte_lane_align u_align (
        .st_off_i  (bus.dm_addr[2:0]),
        .st_bmd_i  (bus.dm_bmd),
        .st_wdata_i(bus.dm_wdata),
        .ld_off_i  (ld_off_q),
        .ld_bmd_i  (ld_bmd_q),
        .ld_rdata_i(bus.mem_rdata),
        .st_mask_o (st_mask),
        .st_wdata_o(st_wdata),
        .st_cross_o(st_cross),
        .ld_rdata_o(ld_rdata)
    );

    // The load-data cycle counts as idle so the next grant overlaps it.
    always_comb begin
        ld_done   = state_q == LOAD_WAIT && cnt_q == 3'd0;
        idle      = state_q == IDLE || ld_done;
        pick_data = bus.dm_req && !(RR_EN && bus.if_req && last_data_q);
        dm_gnt    = idle && pick_data;
        if_gnt    = idle && bus.if_req && !pick_data;
        dm_io     = bus.dm_addr == IO_FILE_POINTER;
    end

    assign bus.dm_gnt    = dm_gnt;
    assign bus.if_gnt    = if_gnt;
    assign bus.if_rvalid = ld_done && ld_fetch_q;
    assign bus.if_rdata  = (ld_done && ld_fetch_q) ? bus.mem_rdata : if_rdata_q;
    assign bus.dm_done   = dm_done_q || (ld_done && !ld_fetch_q);
    assign bus.dm_rdata  = (ld_done && !ld_fetch_q) ? ld_rdata : dm_rdata_q;
    assign bus.dm_err    = dm_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.out_req   = out_req_q;
    assign bus.out_data  = out_data_q;
    assign bus.in_ready  = in_ready_q;

    // Later assignments win, so a grant in the load-data cycle overrides the return to IDLE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ld_off_q    <= '0;
            ld_bmd_q    <= BMD_B;
            ld_fetch_q  <= 1'b0;
            last_data_q <= 1'b0;
            dm_done_q   <= 1'b0;
            dm_err_q    <= 1'b0;
            out_req_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dm_rdata_q  <= '0;
            if_rdata_q  <= '0;
            out_data_q  <= '0;
        end else begin
            mem_we_q  <= '0;
            dm_done_q <= 1'b0;
            dm_err_q  <= 1'b0;
            if (ld_done) begin
                state_q <= IDLE;
                if (ld_fetch_q) if_rdata_q <= bus.mem_rdata;
                else dm_rdata_q <= ld_rdata;
            end else if (state_q == LOAD_WAIT) cnt_q <= cnt_q - 3'd1;
            if (state_q == OUT_WAIT && bus.out_ack) begin
                out_req_q <= 1'b0;
                dm_done_q <= 1'b1;
                state_q   <= IDLE;
            end
            if (state_q == IN_WAIT && bus.in_valid) begin
                in_ready_q <= 1'b0;
                dm_rdata_q <= {32'b0, bus.in_data};
                dm_done_q  <= 1'b1;
                state_q    <= IDLE;
            end
            if (dm_gnt) begin
                last_data_q <= 1'b1;
                if (dm_io) begin
                    if (bus.dm_we) begin
                        out_data_q <= bus.dm_wdata[31:0];
                        out_req_q  <= 1'b1;
                        state_q    <= OUT_WAIT;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= IN_WAIT;
                    end
                end else if (st_cross) dm_err_q <= 1'b1;
                else begin
                    mem_addr_q <= bus.dm_addr & ~addr_t'(7);
                    if (bus.dm_we) begin
                        mem_we_q    <= st_mask;
                        mem_wdata_q <= st_wdata;
                        dm_done_q   <= 1'b1;
                    end else begin
                        state_q    <= LOAD_WAIT;
                        cnt_q      <= 3'(LOAD_LATENCY);
                        ld_off_q   <= bus.dm_addr[2:0];
                        ld_bmd_q   <= bus.dm_bmd;
                        ld_fetch_q <= 1'b0;
                    end
                end
            end else if (if_gnt) begin
                last_data_q <= 1'b0;
                mem_addr_q  <= bus.if_addr & ~addr_t'(7);
                state_q     <= LOAD_WAIT;
                cnt_q       <= 3'(LOAD_LATENCY);
                ld_fetch_q  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb_mem_port_scheduler: directed plus randomized checks against a byte-level memory model
module tb_mem_port_scheduler;
    import mem_port_scheduler_pkg::*;
    localparam int L = 2;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int tests = 0;
    int fails = 0;
    mem_port_scheduler_if bus();
    mem_port_scheduler #(.LOAD_LATENCY(L)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;

    reg_t       mem [128];
    logic [7:0] ref_mem [1024];
    addr_t      apipe [L];
    assign bus.mem_rdata = mem[apipe[L-1][9:3]];

    always @(posedge clk) begin
        apipe[0] <= bus.mem_addr;
        for (int k = 1; k < L; k++) apipe[k] <= apipe[k-1];
        if (!rstn) begin
            for (int w = 0; w < 128; w++)
                for (int k = 0; k < 8; k++) mem[w][8*k +: 8] <= ref_mem[8*w + k];
        end else begin
            for (int k = 0; k < 8; k++)
                if (bus.mem_we[k]) mem[bus.mem_addr[9:3]][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input reg_t got, input reg_t exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic reg_t ref_load(input addr_t a, input bmd_t b);
        reg_t v = '0;
        for (int i = 0; i < (1 << b); i++) v[8*i +: 8] = ref_mem[10'(a + addr_t'(i))];
        return v;
    endfunction

    // Waits (bounded) for the grant, then drops the request in the following cycle.
    task automatic wait_gnt(input bit fetch);
        int n = 0;
        #1;
        while (!(fetch ? bus.if_gnt : bus.dm_gnt) && n < 50) begin
            tick();
            #1;
            n++;
        end
        chk(fetch ? "if_gnt" : "dm_gnt", reg_t'(fetch ? bus.if_gnt : bus.dm_gnt), 1);
        tick();
        if (fetch) bus.if_req = 1'b0;
        else bus.dm_req = 1'b0;
    endtask

    task automatic data_op(input bit we, input addr_t a, input bmd_t b, input reg_t wd);
        int sz = 1 << b;
        int off = int'(a[2:0]);
        logic [7:0] m = '0;
        reg_t exp = ref_load(a, b);
        bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = a; bus.dm_bmd = b; bus.dm_wdata = wd;
        wait_gnt(1'b0);
        #1;
        if (off + sz > 8) begin
            chk("err", reg_t'(bus.dm_err), 1);
            chk("err_we", reg_t'(bus.mem_we), 0);
            chk("err_done", reg_t'(bus.dm_done), 0);
        end else if (we) begin
            for (int i = 0; i < sz; i++) begin
                m[off + i] = 1'b1;
                ref_mem[10'(a + addr_t'(i))] = wd[8*i +: 8];
            end
            chk("st_we", reg_t'(bus.mem_we), reg_t'(m));
            chk("st_addr", reg_t'(bus.mem_addr), reg_t'(a & ~32'd7));
            chk("st_wdata", bus.mem_wdata, wd << (8*off));
            chk("st_done", reg_t'(bus.dm_done), 1);
            tick();
            #1;
            chk("st_we_clr", reg_t'(bus.mem_we), 0);
        end else begin
            chk("ld_early", reg_t'(bus.dm_done), 0);
            repeat (L) tick();
            #1;
            chk("ld_done", reg_t'(bus.dm_done), 1);
            chk("ld_data", bus.dm_rdata, exp);
            tick();
            #1;
            chk("ld_pulse", reg_t'(bus.dm_done), 0);
        end
        tick();
    endtask

    task automatic fetch_op(input addr_t a);
        reg_t exp = ref_load(a, BMD_D);
        bus.if_req = 1'b1; bus.if_addr = a;
        wait_gnt(1'b1);
        repeat (L) tick();
        #1;
        chk("if_rvalid", reg_t'(bus.if_rvalid), 1);
        chk("if_rdata", bus.if_rdata, exp);
        tick();
        #1;
        chk("if_pulse", reg_t'(bus.if_rvalid), 0);
        tick();
    endtask

    task automatic in_op(input int dly, input logic [31:0] d);
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = IO_FILE_POINTER_DEF; bus.dm_bmd = BMD_W;
        wait_gnt(1'b0);
        #1;
        chk("in_ready", reg_t'(bus.in_ready), 1);
        repeat (dly) begin
            tick();
            #1;
            chk("in_wait", reg_t'({bus.in_ready, bus.dm_done}), 2);
        end
        tick();
        bus.in_valid = 1'b1; bus.in_data = d;
        #1;
        chk("in_early", reg_t'(bus.dm_done), 0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("in_done", reg_t'(bus.dm_done), 1);
        chk("in_data", bus.dm_rdata, {32'b0, d});
        chk("in_ready_drop", reg_t'(bus.in_ready), 0);
        tick();
    endtask

    int    kind;
    addr_t ra;
    bmd_t  rb;
    reg_t  ed, ef;

    initial begin
        {bus.if_req, bus.dm_req, bus.dm_we, bus.out_ack, bus.in_valid} = '0;
        bus.if_addr = '0; bus.dm_addr = '0; bus.dm_bmd = BMD_B; bus.dm_wdata = '0; bus.in_data = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        repeat (3) tick();
        #1;
        chk("rst_done", reg_t'({bus.dm_done, bus.dm_err, bus.if_rvalid, bus.out_req, bus.in_ready}), 0);
        chk("rst_we", reg_t'(bus.mem_we), 0);
        chk("rst_addr", reg_t'(bus.mem_addr), 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", bus.dm_rdata | bus.if_rdata, 0);
        chk("rst_out_data", reg_t'(bus.out_data), 0);
        tick();
        rstn = 1'b1;
        tick();
        // simultaneous requests: data wins, fetch is granted in the load-data cycle
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h208; bus.dm_bmd = BMD_D;
        bus.if_req = 1'b1; bus.if_addr = 32'h310;
        ed = ref_load(32'h208, BMD_D);
        ef = ref_load(32'h310, BMD_D);
        #1;
        chk("tie_dm_gnt", reg_t'(bus.dm_gnt), 1);
        chk("tie_if_gnt", reg_t'(bus.if_gnt), 0);
        tick();
        bus.dm_req = 1'b0;
        repeat (L) tick();
        #1;
        chk("tie_ld_done", reg_t'(bus.dm_done), 1);
        chk("tie_ld_data", bus.dm_rdata, ed);
        chk("tie_if_gnt2", reg_t'(bus.if_gnt), 1);
        tick();
        bus.if_req = 1'b0;
        repeat (L) tick();
        #1;
        chk("tie_if_rvalid", reg_t'(bus.if_rvalid), 1);
        chk("tie_if_rdata", bus.if_rdata, ef);
        tick();
        // directed store/load/error cases
        data_op(1'b1, 32'h100, BMD_D, 64'h0011223344556677);
        data_op(1'b0, 32'h105, BMD_B, '0);
        data_op(1'b1, 32'h103, BMD_H, 64'hABCD);
        data_op(1'b0, 32'h100, BMD_D, '0);
        data_op(1'b0, 32'h106, BMD_W, '0);
        data_op(1'b1, 32'h1ff, BMD_D, 64'h1);
        // OUT handshake; an ack during the grant cycle must be ignored
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = IO_FILE_POINTER_DEF; bus.dm_bmd = BMD_W;
        bus.dm_wdata = 64'hdeadbeef_00000041; bus.out_ack = 1'b1;
        wait_gnt(1'b0);
        bus.out_ack = 1'b0;
        #1;
        chk("out_req", reg_t'(bus.out_req), 1);
        chk("out_data", reg_t'(bus.out_data), 64'h41);
        for (int k = 2; k <= 5; k++) begin
            tick();
            if (k == 5) bus.out_ack = 1'b1;
            #1;
            chk("out_wait", reg_t'({bus.out_req, bus.dm_done}), 2);
        end
        tick();
        bus.out_ack = 1'b0;
        #1;
        chk("out_req_drop", reg_t'(bus.out_req), 0);
        chk("out_done", reg_t'(bus.dm_done), 1);
        tick();
        in_op(3, 32'h12345678);
        in_op(0, 32'hcafef00d);
        // randomized mix
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            ra = addr_t'($urandom_range(0, 1023));
            rb = bmd_t'($urandom_range(0, 3));
            if (kind == 2) fetch_op(ra & ~32'd7);
            else data_op(kind == 1, ra, rb, {$urandom, $urandom});
        end
        // reset in the middle of IN_WAIT
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = IO_FILE_POINTER_DEF; bus.dm_bmd = BMD_W;
        wait_gnt(1'b0);
        tick();
        rstn = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 32'h55;
        tick();
        tick();
        rstn = 1'b1;
        #1;
        chk("abort_ready", reg_t'(bus.in_ready), 0);
        chk("abort_done", reg_t'(bus.dm_done), 0);
        tick();
        #1;
        chk("abort_done2", reg_t'({bus.dm_done, bus.in_ready}), 0);
        bus.in_valid = 1'b0;
        tick();
        data_op(1'b0, 32'h100, BMD_D, '0);
        fetch_op(32'h3f8);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_scheduler.md
# mem_port_scheduler

Single-port memory scheduler placed between the fetch unit, the execute-stage memory access unit and the physical data memory / IO. It arbitrates fetch and data requests onto one memory port and converts data addresses and byte modes into physical byte-lane writes. It sequences fixed-latency loads and routes IO_FILE_POINTER accesses to a blocking OUT/IN handshake.

## Interface
- LOAD_LATENCY, 1, cycles from registered mem_addr to valid mem_rdata (1..7)
- IO_FILE_POINTER, 32'hfffff000, data address decoded as IO
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- if_req / if_addr  in  1 / addr_t  fetch request, 8-byte aligned address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid / if_rdata  out  1 / reg_t  fetch data, one-cycle pulse
- dm_req / dm_we / dm_addr / dm_bmd / dm_wdata  in  1 / 1 / addr_t / bmd_t / reg_t  data request
- dm_gnt  out  1  data request accepted (combinational)
- dm_done  out  1  one-cycle pulse: store or OUT complete, or load/IN data valid
- dm_rdata  out  reg_t  load/IN data, zero-extended, valid with dm_done
- dm_err  out  1  one-cycle pulse: access crosses 8-byte boundary, dropped
- mem_addr / mem_we / mem_wdata  out  addr_t / 8 / reg_t  registered memory port
- mem_rdata  in  reg_t  memory read data
- out_req / out_data / out_ack  out / out / in  1 / 32 / 1  OUT handshake
- in_ready / in_valid / in_data  out / in / in  1 / 1 / 32  IN handshake

## Operation
- States: IDLE, LOAD_WAIT, OUT_WAIT, IN_WAIT. Grants only in IDLE.
- Arbitration in IDLE: fixed priority data > fetch (see Configuration). At most one grant per cycle.
- Data store, non-IO: mem_addr <= {dm_addr[..3],3'b0}; mem_we <= lane mask; mem_wdata <= dm_wdata shifted left by 8*dm_addr[2:0]; dm_done next cycle; stay IDLE.
- Lane mask: size = 1/2/4/8 bytes for bmd 0/1/2/3; mask = ((1<<size)-1) << dm_addr[2:0]. If dm_addr[2:0]+size > 8: no write, dm_err next cycle, no dm_done.
- Loads (data or fetch): mem_we <= 0; go LOAD_WAIT; counter loads LOAD_LATENCY. When data valid, data load: dm_rdata = mem_rdata >> 8*offset, masked to size; fetch: if_rdata = mem_rdata raw. Pulse respective valid; return IDLE.
- dm_addr == IO_FILE_POINTER: dm_we=1 → out_data <= dm_wdata[31:0], out_req=1, OUT_WAIT; dm_we=0 → in_ready=1, IN_WAIT. No memory access.
- OUT_WAIT: on out_ack, out_req drops next cycle, dm_done pulses, IDLE. IN_WAIT: on in_valid, dm_rdata <= {32'b0,in_data}, dm_done, in_ready drops, IDLE. Wait unbounded.
- Fetch to IO_FILE_POINTER is a normal memory load.
- mem_we is nonzero for exactly one cycle per store.

## Timing
- Reset: state IDLE; if_gnt, dm_gnt, if_rvalid, dm_done, dm_err, out_req, in_ready, mem_we = 0; mem_addr, mem_wdata, dm_rdata, if_rdata, out_data = 0.
- Grant at cycle T → mem_addr at T+1 → load data and valid pulse at T+1+LOAD_LATENCY; next grant no earlier than that cycle (IDLE re-entered combinationally in the valid cycle).
- Store grant T → dm_done T+1; a new grant is possible at T+1.
- Requesters hold req/addr/data until gnt; may drop req afterwards.
- Simultaneous out_ack/in_valid with entry: handshake inputs are ignored in the entry cycle.
- Reset mid-operation aborts any wait; no valid/done pulse is issued for the aborted request.

## Configuration
- MEM_SCHED_RR_EN defined: round-robin arbitration; the last-granted requester loses a tie; pointer resets to "fetch last" (data wins first tie).
- Undefined: fixed data-over-fetch priority; fetch can starve under continuous data requests.

## Structure
- Shared package: addr_t, reg_t, bmd_t, bmd encodings, IO_FILE_POINTER default, state enum mem_sched_state_t.
- Sub-module byte_lane_align: combinational lane mask, store shift, load extract/zero-extend, crossing check; reusable by the cache later.

## Test plan
- Store bmd=1 (2 bytes), addr 0x103, data 0xABCD → mem_addr 0x100, mem_we 8'b0001_1000, mem_wdata[39:24]=0xABCD, dm_done next cycle.
- LOAD_LATENCY=2, load bmd=0 at 0x105, mem_rdata 0x0011223344556677 → dm_rdata 0x22 at grant+3, dm_done single pulse.
- Simultaneous if_req and dm_req in IDLE → dm_gnt only; fetch granted when data load completes; with MEM_SCHED_RR_EN, second tie grants fetch.
- Store to 0xfffff000, data 0x41, out_ack after 5 cycles → out_req high 5 cycles, out_data 0x41, dm_done on ack+1.
- Load bmd=2 at 0x106 → dm_err pulse, mem_we stays 0, no dm_done.
- rstn low during IN_WAIT → in_ready 0 and state IDLE after reset, no dm_done; next request served normally.
